// File: rtl/time_set_ctrl.sv
// time_set_ctrl: button-driven editor for the clock's hour/minute/second
// counter and the 16-bit alarm register. Fields are edited in BCD, time
// fields are pushed to the counter with one-cycle SET/SETDATA strobes, and
// the counter is held (EN=0) while a time field is being edited.
module time_set_ctrl #(
    parameter logic [15:0] ALERT_INIT = 16'h0700,
    parameter int          TIMEOUT    = 10000
) (
    input  logic        Clk,
    input  logic        RST,
    input  logic        BtnMode,
    input  logic        BtnInc,
    input  logic        BtnDec,
    input  logic [7:0]  CurHours,
    input  logic [7:0]  CurMinutes,
    input  logic [7:0]  CurSeconds,
    output logic [1:0]  SET,
    output logic [7:0]  SETDATA,
    output logic        EN,
    output logic [15:0] Alert,
    output logic [7:0]  EditData,
    output logic [2:0]  EditField
);

    localparam int CW = $clog2(TIMEOUT + 1);

    // Encoding doubles as the EditField display value.
    typedef enum logic [2:0] {
        S_RUN   = 3'd0,
        S_HOUR  = 3'd1,
        S_MIN   = 3'd2,
        S_SEC   = 3'd3,
        S_AHOUR = 3'd4,
        S_AMIN  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    edit_q, edit_d;
    logic [1:0]    set_q, set_d;
    logic [7:0]    setdata_q, setdata_d;
    logic          en_q, en_d;
    logic [15:0]   alert_q, alert_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    prev_q, prev_d;   // {mode, inc, dec} from the previous cycle

    logic mode_e, inc_e, dec_e;
    logic [7:0] fmax;

    // Sources outside the legal range for the field start the edit at 00.
    function automatic logic [7:0] bcd_load(input logic [7:0] v, input logic [7:0] mx);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > mx)
            return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] mx);
        if (v == mx)          return 8'h00;
        if (v[3:0] == 4'd9)   return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] mx);
        if (v == 8'h00)       return mx;
        if (v[3:0] == 4'd0)   return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    assign mode_e = BtnMode & ~prev_q[2];
    assign inc_e  = BtnInc  & ~prev_q[1];
    assign dec_e  = BtnDec  & ~prev_q[0];
    assign fmax   = (state_q == S_HOUR || state_q == S_AHOUR) ? 8'h23 : 8'h59;

    // Next-state: Mode commits/advances, then Inc/Dec, then idle timeout.
    always_comb begin
        state_d   = state_q;
        edit_d    = edit_q;
        set_d     = 2'b00;
        setdata_d = 8'h00;
        en_d      = en_q;
        alert_d   = alert_q;
        cnt_d     = cnt_q;
        prev_d    = {BtnMode, BtnInc, BtnDec};

        if (state_q == S_RUN) begin
            if (mode_e) begin
                state_d = S_HOUR;
                edit_d  = bcd_load(CurHours, 8'h23);
                en_d    = 1'b0;
                cnt_d   = '0;
            end
        end else if (mode_e) begin
            cnt_d = '0;
            unique case (state_q)
                S_HOUR: begin
                    set_d     = 2'b01;
                    setdata_d = edit_q;
                    state_d   = S_MIN;
                    edit_d    = bcd_load(CurMinutes, 8'h59);
                    en_d      = 1'b0;
                end
                S_MIN: begin
                    set_d     = 2'b10;
                    setdata_d = edit_q;
                    state_d   = S_SEC;
                    edit_d    = bcd_load(CurSeconds, 8'h59);
                    en_d      = 1'b0;
                end
                S_SEC: begin
                    set_d     = 2'b11;
                    setdata_d = edit_q;
                    state_d   = S_AHOUR;
                    edit_d    = bcd_load(alert_q[15:8], 8'h23);
                    en_d      = 1'b1;
                end
                S_AHOUR: begin
                    alert_d[15:8] = edit_q;
                    state_d       = S_AMIN;
                    edit_d        = bcd_load(alert_q[7:0], 8'h59);
                    en_d          = 1'b1;
                end
                default: begin
                    // S_AMIN commit, and recovery from unused encodings
                    if (state_q == S_AMIN)
                        alert_d[7:0] = edit_q;
                    state_d = S_RUN;
                    edit_d  = 8'h00;
                    en_d    = 1'b1;
                end
            endcase
        end else if (inc_e || dec_e) begin
            cnt_d = '0;
            if (inc_e && !dec_e)
                edit_d = bcd_inc(edit_q, fmax);
            else if (dec_e && !inc_e)
                edit_d = bcd_dec(edit_q, fmax);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            // Abandon the current field without committing it.
            state_d = S_RUN;
            edit_d  = 8'h00;
            en_d    = 1'b1;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // State and registered outputs; button history loads 1 so held buttons don't fire.
    always_ff @(posedge Clk) begin
        if (RST) begin
            state_q   <= S_RUN;
            edit_q    <= 8'h00;
            set_q     <= 2'b00;
            setdata_q <= 8'h00;
            en_q      <= 1'b1;
            alert_q   <= ALERT_INIT;
            cnt_q     <= '0;
            prev_q    <= 3'b111;
        end else begin
            state_q   <= state_d;
            edit_q    <= edit_d;
            set_q     <= set_d;
            setdata_q <= setdata_d;
            en_q      <= en_d;
            alert_q   <= alert_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
        end
    end

    assign SET       = set_q;
    assign SETDATA   = setdata_q;
    assign EN        = en_q;
    assign Alert     = alert_q;
    assign EditData  = edit_q;
    assign EditField = state_q;

endmodule
